// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC rotation and vectoring stages.
// Covers operand widths, angle limits, the arctangent table and the FSM encoding.
package cordic_pkg;

  localparam int W    = 9;
  localparam int IW   = 11;
  localparam int ITER = 8;
  localparam int ZW   = W + 1;
  localparam int CW   = 3;

  localparam logic signed [ZW-1:0] ANGLE_PI_2 = 10'sd128;
  localparam logic signed [ZW-1:0] ANGLE_MAX  = 10'sd255;
  localparam logic signed [ZW-1:0] ANGLE_MIN  = -10'sd256;

  typedef logic signed [W-1:0] angle_t;

  // atan(2^-i) in units of pi/256
  localparam angle_t ATAN_TABLE [0:ITER-1] = '{
    9'sd64, 9'sd38, 9'sd20, 9'sd10, 9'sd5, 9'sd3, 9'sd1, 9'sd1
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROT  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cordic_atan_lut.sv
// Combinational arctangent lookup indexed by micro-rotation number.
// Shared by the rotation and vectoring stages so both use identical angle constants.
module cordic_atan_lut
  import cordic_pkg::*;
(
  input  logic [CW-1:0] idx,
  output logic [W-1:0]  angle
);

  always_comb begin
    angle = ATAN_TABLE[idx];
  end

endmodule

// File: rtl/cordic_vector_engine.sv
// Iterative vectoring-mode CORDIC: rotates (x, y) onto the x axis one step per clock
// and reports the K-scaled magnitude and the accumulated phase angle.
module cordic_vector_engine
  import cordic_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] x_in,
  input  logic [W-1:0] y_in,
  output logic         busy,
  output logic         done,
  output logic [W:0]   mag_out,
  output logic [W-1:0] angle_out
);

  state_t state, state_nxt;

  logic [CW-1:0]         cnt;
  logic signed [IW-1:0]  x_r, y_r;
  logic signed [ZW-1:0]  z_r;
  logic signed [IW-1:0]  x_ext, y_ext;
  logic signed [IW-1:0]  x_pre, y_pre;
  logic signed [ZW-1:0]  z_pre;
  logic signed [IW-1:0]  x_sh, y_sh;
  logic signed [IW-1:0]  x_nxt, y_nxt;
  logic signed [ZW-1:0]  z_nxt;
  logic [W-1:0]          atan_raw;
  logic signed [ZW-1:0]  atan_ext;
  logic                  last_iter;

  function automatic logic [W-1:0] sat_angle(input logic signed [ZW-1:0] z);
    logic [W-1:0] r;
    if (z > ANGLE_MAX)      r = ANGLE_MAX[W-1:0];
    else if (z < ANGLE_MIN) r = ANGLE_MIN[W-1:0];
    else                    r = z[W-1:0];
    return r;
  endfunction

  cordic_atan_lut u_atan (
    .idx   (cnt),
    .angle (atan_raw)
  );

  assign atan_ext  = {atan_raw[W-1], atan_raw};
  assign last_iter = (cnt == CW'(ITER - 1));

  // Operand capture: fold left half-plane vectors into the right half-plane
  assign x_ext = {{(IW-W){x_in[W-1]}}, x_in};
  assign y_ext = {{(IW-W){y_in[W-1]}}, y_in};

  always_comb begin
    x_pre = x_ext;
    y_pre = y_ext;
    z_pre = '0;
    if (x_in[W-1]) begin
      if (!y_in[W-1]) begin
        x_pre = y_ext;
        y_pre = -x_ext;
        z_pre = ANGLE_PI_2;
      end else begin
        x_pre = -y_ext;
        y_pre = x_ext;
        z_pre = -ANGLE_PI_2;
      end
    end
  end

  // Micro-rotation: every update uses the pre-update x/y/z
  assign x_sh = x_r >>> cnt;
  assign y_sh = y_r >>> cnt;

  always_comb begin
    if (!y_r[IW-1]) begin
      x_nxt = x_r + y_sh;
      y_nxt = y_r - x_sh;
      z_nxt = z_r + atan_ext;
    end else begin
      x_nxt = x_r - y_sh;
      y_nxt = y_r + x_sh;
      z_nxt = z_r - atan_ext;
    end
  end

  // Control FSM
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_ROT;
      ST_ROT: begin
        busy = 1'b1;
        if (last_iter) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Iteration registers and result latch; results also clear on reset
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt       <= '0;
      x_r       <= '0;
      y_r       <= '0;
      z_r       <= '0;
      mag_out   <= '0;
      angle_out <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            x_r <= x_pre;
            y_r <= y_pre;
            z_r <= z_pre;
            cnt <= '0;
          end
        end
        ST_ROT: begin
          x_r <= x_nxt;
          y_r <= y_nxt;
          z_r <= z_nxt;
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            mag_out   <= x_nxt[W:0];
            angle_out <= sat_angle(z_nxt);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vector_engine.sv
// Bench for cordic_vector_engine: vector table through a result queue, plus
// handshake, back-to-back and mid-operation reset sequences.
module tb_cordic_vector_engine;
  import cordic_pkg::*;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] x_in;
  logic [W-1:0] y_in;
  logic         busy;
  logic         done;
  logic [W:0]   mag_out;
  logic [W-1:0] angle_out;

  typedef struct {
    int x;
    int y;
    int mag;
    int mtol;
    int ang;
    int atol;
    bit chk_ang;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  cordic_vector_engine dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .x_in      (x_in),
    .y_in      (y_in),
    .busy      (busy),
    .done      (done),
    .mag_out   (mag_out),
    .angle_out (angle_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act < exp - tol || act > exp + tol) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (+/-%0d)", name, act, exp, tol);
    end
  endtask

  // Results are popped from the queue and compared whenever done is seen
  always @(negedge clock) begin : monitor
    vec_t e;
    if (!reset && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 mag=%0d, want no pending operation", mag_out);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("mag(%0d,%0d)", e.x, e.y), int'(mag_out), e.mag, e.mtol);
        if (e.chk_ang)
          check($sformatf("angle(%0d,%0d)", e.x, e.y), int'($signed(angle_out)), e.ang, e.atol);
      end
    end
  end

  // Entered and left at a negedge in IDLE; the sampling edge counts as edge 1
  task automatic run_op(input vec_t v);
    int edges;
    int bcyc;
    bit seen;
    edges = 0;
    bcyc  = 0;
    seen  = 1'b0;
    x_in  = 9'(v.x);
    y_in  = 9'(v.y);
    start = 1'b1;
    exp_q.push_back(v);
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clock);
      edges++;
      @(negedge clock);
      start = 1'b0;
      if (busy) bcyc++;
      if (done) seen = 1'b1;
    end
    check($sformatf("start_to_done_edges(%0d,%0d)", v.x, v.y), seen ? edges : -1, 9, 0);
    check($sformatf("busy_cycles(%0d,%0d)", v.x, v.y), bcyc, 8, 0);
    @(negedge clock);
    check("done_pulse_width", int'(done), 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   d0;

    reset = 1'b1;
    start = 1'b0;
    x_in  = '0;
    y_in  = '0;

    vecs.push_back('{100,    0, 165, 2,    0, 2, 1'b1});
    vecs.push_back('{100,  100, 233, 3,   64, 2, 1'b1});
    vecs.push_back('{0,    100, 165, 2,  128, 2, 1'b1});
    vecs.push_back('{-100,   0, 165, 2,  255, 2, 1'b1});
    vecs.push_back('{-256,-256, 596, 4, -192, 2, 1'b1});
    vecs.push_back('{0,   -100, 165, 2, -128, 2, 1'b1});
    vecs.push_back('{-100, 100, 233, 3,  192, 2, 1'b1});
    vecs.push_back('{-100,-100, 233, 3, -192, 2, 1'b1});
    vecs.push_back('{255, -255, 594, 4,  -64, 2, 1'b1});
    vecs.push_back('{200,   50, 339, 3,   20, 2, 1'b1});
    vecs.push_back('{0,      0,   0, 0,    0, 0, 1'b0});

    repeat (3) @(negedge clock);
    check("reset_busy",  int'(busy), 0, 0);
    check("reset_done",  int'(done), 0, 0);
    check("reset_mag",   int'(mag_out), 0, 0);
    check("reset_angle", int'(angle_out), 0, 0);
    reset = 1'b0;

    // Table runs back to back: each start lands in the IDLE cycle after DONE
    foreach (vecs[i]) run_op(vecs[i]);

    // A second start during ROT must be ignored
    d0    = done_cnt;
    v     = '{100, 100, 233, 3, 64, 2, 1'b1};
    exp_q.push_back(v);
    x_in  = 9'(100);
    y_in  = 9'(100);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    x_in  = 9'(-50);
    y_in  = 9'(50);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (20) @(negedge clock);
    check("single_done_on_restart", done_cnt - d0, 1, 0);
    check("queue_drained", exp_q.size(), 0, 0);

    // Reset while counter is 4 aborts without a done pulse
    x_in  = 9'(100);
    y_in  = 9'(0);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("abort_busy",  int'(busy), 0, 0);
    check("abort_done",  int'(done), 0, 0);
    check("abort_mag",   int'(mag_out), 0, 0);
    check("abort_angle", int'(angle_out), 0, 0);
    reset = 1'b0;
    d0 = done_cnt;
    repeat (15) @(negedge clock);
    check("no_done_after_abort", done_cnt - d0, 0, 0);

    v = '{0, 100, 165, 2, 128, 2, 1'b1};
    run_op(v);
    check("final_queue_empty", exp_q.size(), 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
